// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait freeze.
// A memory access that never completes escalates to a sticky ERROR state left only by reset.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             if_id_rs,
  input  logic [2:0]             if_id_rt,
  input  logic                   if_id_uses_rt,
  input  logic                   id_ex_mem_read,
  input  logic [2:0]             id_ex_rd,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   pipe_freeze,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e                 r_state;
  logic [7:0]             r_wait_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   r_mem_timeout;
  logic                   w_freeze;
  logic                   w_load_use;

  always_comb begin
    w_freeze = 1'b1;
    case (r_state)
      RUN:      w_freeze = dmem_req & ~dmem_ready;
      MEM_WAIT: w_freeze = ~dmem_ready;
      default:  w_freeze = 1'b1;
    endcase
  end

  assign w_load_use = id_ex_mem_read & (id_ex_rd != 3'd0) &
                      ((id_ex_rd == if_id_rs) | (if_id_uses_rt & (id_ex_rd == if_id_rt)));

  // Outputs are forced to the held-pipeline pattern while reset is low, independent of clk.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst_n) begin
      if (w_freeze) begin
        pipe_freeze  = 1'b1;
      end else if (branch_taken) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_stall_cycles <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      if (!pc_write && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      case (r_state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == TIMEOUT) begin
            r_state       <= ERROR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ERROR:   r_mem_timeout <= 1'b1;
        default: r_state <= RUN;
      endcase
    end
  end

  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule
